// File: rtl/rf_arb_pkg.sv
// Shared constants, FSM state type and one-hot decode for the register-file read arbiter.
package rf_arb_pkg;
  localparam int NREQ   = 4;
  localparam int IDX_W  = 3;
  localparam int DATA_W = 16;

  typedef enum logic {IDLE, GRANT} state_t;

  function automatic logic [1:0] onehot_to_id(input logic [NREQ-1:0] oh);
    logic [1:0] id;
    id = 2'd0;
    if (oh[1]) id = 2'd1;
    if (oh[2]) id = 2'd2;
    if (oh[3]) id = 2'd3;
    return id;
  endfunction
endpackage

// File: rtl/rr_pick4.sv
// Combinational rotating-priority picker: first eligible requester at or after ptr wins.
module rr_pick4
  import rf_arb_pkg::*;
(
  input  logic [NREQ-1:0] eligible,
  input  logic [1:0]      ptr,
  output logic [NREQ-1:0] winner,
  output logic            valid
);
  logic [1:0] j;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    j      = 2'd0;
    for (int i = 0; i < NREQ; i++) begin
      j = ptr + 2'(i);
      if (!valid && eligible[j]) begin
        winner[j] = 1'b1;
        valid     = 1'b1;
      end
    end
  end
endmodule

// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter sharing one 8-way register mux among four readers; grant, then registered data next cycle.
// Optional RFARB_LOCK_EN adds a LOCK input letting the current grantee hold the mux on consecutive cycles.
module regfile_read_arbiter #(
  parameter int DATA_W = rf_arb_pkg::DATA_W,
  parameter int IDX_W  = rf_arb_pkg::IDX_W
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [3:0]          REQ,
  input  logic [4*IDX_W-1:0]  IDX,
  input  logic [DATA_W-1:0]   MUX_O,
  output logic [IDX_W-1:0]    S,
  output logic [3:0]          GNT,
  output logic                RVALID,
  output logic [DATA_W-1:0]   RDATA,
  output logic [1:0]          RID
`ifdef RFARB_LOCK_EN
  ,
  input  logic [3:0]          LOCK
`endif
);
  import rf_arb_pkg::*;

  state_t            state, state_nxt;
  logic [NREQ-1:0]   active, eligible, win, gnt_nxt;
  logic              win_vld, lock_hit;
  logic [1:0]        ptr, ptr_nxt;
  logic [IDX_W-1:0]  s_nxt;

  // The requester holding the grant this cycle sits out the next pick.
  assign active   = (state == GRANT) ? GNT : '0;
  assign eligible = REQ & ~active;

`ifdef RFARB_LOCK_EN
  assign lock_hit = |(active & REQ & LOCK);
`else
  assign lock_hit = 1'b0;
`endif

  rr_pick4 u_pick (
    .eligible (eligible),
    .ptr      (ptr),
    .winner   (win),
    .valid    (win_vld)
  );

  always_comb begin
    state_nxt = IDLE;
    gnt_nxt   = '0;
    ptr_nxt   = ptr;
    s_nxt     = S;
    if (lock_hit) begin
      state_nxt = GRANT;
      gnt_nxt   = active;
    end else if (win_vld) begin
      state_nxt = GRANT;
      gnt_nxt   = win;
      ptr_nxt   = onehot_to_id(win) + 2'd1;
    end
    if (state_nxt == GRANT)
      s_nxt = IDX[onehot_to_id(gnt_nxt)*IDX_W +: IDX_W];
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state  <= IDLE;
      GNT    <= '0;
      ptr    <= 2'd0;
      S      <= '0;
      RVALID <= 1'b0;
      RDATA  <= '0;
      RID    <= 2'd0;
    end else begin
      state  <= state_nxt;
      GNT    <= gnt_nxt;
      ptr    <= ptr_nxt;
      S      <= s_nxt;
      RVALID <= (state == GRANT);
      // MUX_O reflects S during the grant cycle; capture it as that cycle ends.
      if (state == GRANT) begin
        RDATA <= MUX_O;
        RID   <= onehot_to_id(GNT);
      end
    end
  end
endmodule
